// File: rtl/sdram_burst_sched.sv
// Multi-channel SDRAM burst scheduler: round-robin picks one write or read
// burst at a time from per-channel FIFO levels and wrapping address windows.
module sdram_burst_sched #(
    parameter int CH_NUM     = 2,
    parameter int ADDR_W     = 24,
    parameter int LEN_W      = 10,
    parameter int CNT_W      = 10,
    parameter int FIFO_DEPTH = 1024,
    parameter int WR_PRIO    = 1
) (
    input  logic                     sdram_clk,
    input  logic                     sdram_rst,
    input  logic                     init_end,
    input  logic [CH_NUM*CNT_W-1:0]  ch_wr_num,
    input  logic [CH_NUM*CNT_W-1:0]  ch_rd_num,
    input  logic [CH_NUM-1:0]        ch_rd_valid,
    input  logic [CH_NUM-1:0]        ch_wr_rst,
    input  logic [CH_NUM-1:0]        ch_rd_rst,
    input  logic [CH_NUM*ADDR_W-1:0] ch_wr_addr_start,
    input  logic [CH_NUM*ADDR_W-1:0] ch_wr_addr_end,
    input  logic [CH_NUM*ADDR_W-1:0] ch_rd_addr_start,
    input  logic [CH_NUM*ADDR_W-1:0] ch_rd_addr_end,
    input  logic [CH_NUM*LEN_W-1:0]  ch_wr_bst_len,
    input  logic [CH_NUM*LEN_W-1:0]  ch_rd_bst_len,
    input  logic                     sdram_wr_ack,
    input  logic                     sdram_rd_ack,
    output logic                     sdram_wr_req,
    output logic                     sdram_rd_req,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic [LEN_W-1:0]         sdram_bst_len,
    output logic [CH_NUM-1:0]        ch_sel
);

    localparam int PW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CW = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
    localparam int AW = ADDR_W + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              alt_wr_q, alt_wr_d;
    logic [CH_NUM-1:0] ch_sel_q, ch_sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              wr_req_q, wr_req_d;
    logic              rd_req_q, rd_req_d;
    logic              is_wr_q, is_wr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic              ack_dly_q, ack_dly_d;
    logic              sup_q, sup_d;
    logic [ADDR_W-1:0] wr_addr_q [CH_NUM];
    logic [ADDR_W-1:0] wr_addr_d [CH_NUM];
    logic [ADDR_W-1:0] rd_addr_q [CH_NUM];
    logic [ADDR_W-1:0] rd_addr_d [CH_NUM];

    logic [ADDR_W-1:0] wr_start [CH_NUM];
    logic [ADDR_W-1:0] wr_end   [CH_NUM];
    logic [ADDR_W-1:0] rd_start [CH_NUM];
    logic [ADDR_W-1:0] rd_end   [CH_NUM];
    logic [LEN_W-1:0]  wr_len   [CH_NUM];
    logic [LEN_W-1:0]  rd_len   [CH_NUM];
    logic [CH_NUM-1:0] wr_elig, rd_elig;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign wr_start[g] = ch_wr_addr_start[g*ADDR_W +: ADDR_W];
        assign wr_end[g]   = ch_wr_addr_end[g*ADDR_W +: ADDR_W];
        assign rd_start[g] = ch_rd_addr_start[g*ADDR_W +: ADDR_W];
        assign rd_end[g]   = ch_rd_addr_end[g*ADDR_W +: ADDR_W];
        assign wr_len[g]   = ch_wr_bst_len[g*LEN_W +: LEN_W];
        assign rd_len[g]   = ch_rd_bst_len[g*LEN_W +: LEN_W];
        assign wr_elig[g]  = (wr_len[g] != '0) &&
                             (CW'(ch_wr_num[g*CNT_W +: CNT_W]) >= CW'(wr_len[g]));
        assign rd_elig[g]  = ch_rd_valid[g] && (rd_len[g] != '0) &&
                             ((CW'(ch_rd_num[g*CNT_W +: CNT_W]) + CW'(rd_len[g]))
                              <= DEPTH_C);
    end

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base,
                                             input int k);
        int s;
        s = int'(base) + k;
        if (s >= CH_NUM) s = s - CH_NUM;
        return PW'(s);
    endfunction

    logic          wr_any, rd_any;
    logic [PW-1:0] wr_pick, rd_pick;

    always_comb begin
        wr_any  = 1'b0;
        rd_any  = 1'b0;
        wr_pick = '0;
        rd_pick = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (!wr_any && wr_elig[rr_idx(wr_ptr_q, k)]) begin
                wr_any  = 1'b1;
                wr_pick = rr_idx(wr_ptr_q, k);
            end
            if (!rd_any && rd_elig[rr_idx(rd_ptr_q, k)]) begin
                rd_any  = 1'b1;
                rd_pick = rr_idx(rd_ptr_q, k);
            end
        end
    end

    logic          take_wr;
    logic [PW-1:0] pick;
    logic          cur_ack, cur_rst;
    logic [PW-1:0] nxt_ptr;

    always_comb begin
        if (WR_PRIO != 0) take_wr = wr_any;
        else              take_wr = wr_any && (!rd_any || alt_wr_q);
    end

    assign pick    = take_wr ? wr_pick : rd_pick;
    assign cur_ack = is_wr_q ? sdram_wr_ack : sdram_rd_ack;
    assign cur_rst = is_wr_q ? ch_wr_rst[gnt_q] : ch_rd_rst[gnt_q];
    assign nxt_ptr = (gnt_q == PW'(CH_NUM - 1)) ? '0 : gnt_q + 1'b1;

    // Wrap back to start whenever the following burst would pass end.
    logic [AW-1:0]     nxt, nxt_end;
    logic [ADDR_W-1:0] win_start, win_end, upd_addr;

    assign win_start = is_wr_q ? wr_start[gnt_q] : rd_start[gnt_q];
    assign win_end   = is_wr_q ? wr_end[gnt_q] : rd_end[gnt_q];
    assign nxt       = AW'(addr_q) + AW'(len_q);
    assign nxt_end   = nxt + AW'(len_q);
    assign upd_addr  = (nxt_end > AW'(win_end)) ? win_start : nxt[ADDR_W-1:0];

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        alt_wr_d  = alt_wr_q;
        ch_sel_d  = ch_sel_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wr_req_d  = wr_req_q;
        rd_req_d  = rd_req_q;
        is_wr_d   = is_wr_q;
        gnt_d     = gnt_q;
        sup_d     = sup_q;
        ack_dly_d = cur_ack;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;

        unique case (state_q)
            IDLE: begin
                if (init_end && (wr_any || rd_any)) begin
                    state_d        = REQ;
                    is_wr_d        = take_wr;
                    gnt_d          = pick;
                    ch_sel_d       = '0;
                    ch_sel_d[pick] = 1'b1;
                    addr_d   = take_wr ? wr_addr_q[pick] : rd_addr_q[pick];
                    len_d    = take_wr ? wr_len[pick] : rd_len[pick];
                    wr_req_d = take_wr;
                    rd_req_d = !take_wr;
                    sup_d    = take_wr ? ch_wr_rst[pick] : ch_rd_rst[pick];
                    if (WR_PRIO == 0 && wr_any && rd_any)
                        alt_wr_d = !alt_wr_q;
                end
            end
            REQ: begin
                sup_d = sup_q || cur_rst;
                if (cur_ack) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    state_d  = XFER;
                end
            end
            XFER: begin
                sup_d = sup_q || cur_rst;
                if (!cur_ack && ack_dly_q) state_d = DONE;
            end
            DONE: begin
                if (!sup_q) begin
                    if (is_wr_q) wr_addr_d[gnt_q] = upd_addr;
                    else         rd_addr_d[gnt_q] = upd_addr;
                end
                if (is_wr_q) wr_ptr_d = nxt_ptr;
                else         rd_ptr_d = nxt_ptr;
                ch_sel_d = '0;
                sup_d    = 1'b0;
                state_d  = IDLE;
            end
        endcase

        // Channel reloads take precedence over the post-burst update.
        for (int i = 0; i < CH_NUM; i++) begin
            if (ch_wr_rst[i]) wr_addr_d[i] = wr_start[i];
            if (ch_rd_rst[i]) rd_addr_d[i] = rd_start[i];
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            alt_wr_q  <= 1'b1;
            ch_sel_q  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            is_wr_q   <= 1'b0;
            gnt_q     <= '0;
            ack_dly_q <= 1'b0;
            sup_q     <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                wr_addr_q[i] <= wr_start[i];
                rd_addr_q[i] <= rd_start[i];
            end
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            alt_wr_q  <= alt_wr_d;
            ch_sel_q  <= ch_sel_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            is_wr_q   <= is_wr_d;
            gnt_q     <= gnt_d;
            ack_dly_q <= ack_dly_d;
            sup_q     <= sup_d;
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign sdram_wr_req  = wr_req_q;
    assign sdram_rd_req  = rd_req_q;
    assign sdram_addr    = addr_q;
    assign sdram_bst_len = len_q;
    assign ch_sel        = ch_sel_q;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Bench for sdram_burst_sched: a scoreboard of expected bursts is checked
// at every request rise; a second instance covers write/read alternation.
module tb_sdram_burst_sched;

    localparam int CH = 2;
    localparam int AW = 24;
    localparam int LW = 10;
    localparam int CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, rst0, init_end;
    logic [CH*CW-1:0] wr_num, rd_num;
    logic [CH-1:0]   rd_valid, wr_rst, rd_rst;
    logic [CH*AW-1:0] wr_start, wr_end, rd_start, rd_end;
    logic [CH*LW-1:0] wr_len, rd_len;
    logic            wr_ack, rd_ack, wr_ack0, rd_ack0;
    logic            wr_req, rd_req, wr_req0, rd_req0;
    logic [AW-1:0]   addr, addr0;
    logic [LW-1:0]   len, len0;
    logic [CH-1:0]   ch_sel, ch_sel0;

    sdram_burst_sched #(.CH_NUM(CH), .WR_PRIO(1)) u_dut (
        .sdram_clk(clk), .sdram_rst(rst), .init_end(init_end),
        .ch_wr_num(wr_num), .ch_rd_num(rd_num), .ch_rd_valid(rd_valid),
        .ch_wr_rst(wr_rst), .ch_rd_rst(rd_rst),
        .ch_wr_addr_start(wr_start), .ch_wr_addr_end(wr_end),
        .ch_rd_addr_start(rd_start), .ch_rd_addr_end(rd_end),
        .ch_wr_bst_len(wr_len), .ch_rd_bst_len(rd_len),
        .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack),
        .sdram_wr_req(wr_req), .sdram_rd_req(rd_req),
        .sdram_addr(addr), .sdram_bst_len(len), .ch_sel(ch_sel)
    );

    sdram_burst_sched #(.CH_NUM(CH), .WR_PRIO(0)) u_alt (
        .sdram_clk(clk), .sdram_rst(rst0), .init_end(init_end),
        .ch_wr_num(wr_num), .ch_rd_num(rd_num), .ch_rd_valid(rd_valid),
        .ch_wr_rst(wr_rst), .ch_rd_rst(rd_rst),
        .ch_wr_addr_start(wr_start), .ch_wr_addr_end(wr_end),
        .ch_rd_addr_start(rd_start), .ch_rd_addr_end(rd_end),
        .ch_wr_bst_len(wr_len), .ch_rd_bst_len(rd_len),
        .sdram_wr_ack(wr_ack0), .sdram_rd_ack(rd_ack0),
        .sdram_wr_req(wr_req0), .sdram_rd_req(rd_req0),
        .sdram_addr(addr0), .sdram_bst_len(len0), .ch_sel(ch_sel0)
    );

    typedef struct {
        bit            wr;
        int            ch;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    logic [CH-1:0] mon_oh;
    int total = 0;
    int bad   = 0;
    logic wr_p = 1'b0;
    logic rd_p = 1'b0;

    always @(negedge clk) begin
        if ((wr_req && !wr_p) || (rd_req && !rd_p)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got wr=%0b rd=%0b addr=%h, required no burst",
                         wr_req, rd_req, addr);
            end else begin
                me = sb.pop_front();
                mon_oh = 2'b01 << me.ch;
                if ({wr_req, rd_req, addr, len, ch_sel} !==
                    {me.wr, !me.wr, me.addr, me.len, mon_oh}) begin
                    bad++;
                    $display("FAIL sb_burst: got wr=%0b rd=%0b addr=%h len=%0d sel=%b, required wr=%0b addr=%h len=%0d sel=%b",
                             wr_req, rd_req, addr, len, ch_sel,
                             me.wr, me.addr, me.len, mon_oh);
                end
            end
        end
        wr_p = wr_req;
        rd_p = rd_req;
    end

    task automatic push(input bit w, input int c, input logic [AW-1:0] a,
                        input logic [LW-1:0] l);
        exp_t e;
        e.wr = w; e.ch = c; e.addr = a; e.len = l;
        sb.push_back(e);
    endtask

    task automatic set_ack(input int dut, input bit w, input logic v);
        if (dut == 0) begin
            if (w) wr_ack = v; else rd_ack = v;
        end else begin
            if (w) wr_ack0 = v; else rd_ack0 = v;
        end
    endtask

    task automatic wait_req(input int dut, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 80; t++) begin
            if (dut == 0 ? (wr_req || rd_req) : (wr_req0 || rd_req0)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_timeout: dut=%0d got no request, required one within 80 cycles", dut);
        end
    endtask

    task automatic do_burst(input int dut, input int ncyc, input int rst_at,
                            output bit was_wr, output logic [AW-1:0] a,
                            output bit req_low);
        bit ok;
        was_wr  = 1'b0;
        a       = '0;
        req_low = 1'b0;
        wait_req(dut, ok);
        if (!ok) return;
        was_wr = (dut == 0) ? wr_req : wr_req0;
        a      = (dut == 0) ? addr : addr0;
        set_ack(dut, was_wr, 1'b1);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (c == 0)
                req_low = (dut == 0) ? !(wr_req || rd_req) : !(wr_req0 || rd_req0);
            wr_rst[0] = (c == rst_at);
        end
        wr_rst[0] = 1'b0;
        set_ack(dut, was_wr, 1'b0);
    endtask

    task automatic apply_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    bit            bw, brl, bok;
    logic [AW-1:0] ba;

    task automatic test_reset();
        bit seen = 1'b0;
        total++;
        if ({wr_req, rd_req} !== 2'b00) begin
            bad++;
            $display("FAIL reset_req: got %b, required 00", {wr_req, rd_req});
        end
        total++;
        if ({addr, len} !== '0) begin
            bad++;
            $display("FAIL reset_addr_len: got addr=%h len=%0d, required 0 0", addr, len);
        end
        total++;
        if ({ch_sel, ch_sel0} !== '0) begin
            bad++;
            $display("FAIL reset_sel: got %b/%b, required 00/00", ch_sel, ch_sel0);
        end
        wr_num[0 +: CW] = 10'd16;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr_req || rd_req) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL init_gate: got a request with init_end=0, required none");
        end
        wr_num = '0;
    endtask

    task automatic test_wrap();
        init_end = 1'b1;
        push(1, 0, 24'h00, 10'd16);
        push(1, 0, 24'h10, 10'd16);
        push(1, 0, 24'h20, 10'd16);
        push(1, 0, 24'h30, 10'd16);
        push(1, 0, 24'h00, 10'd16);
        wr_num[0 +: CW] = 10'd16;
        for (int i = 0; i < 5; i++) do_burst(0, 16, -1, bw, ba, brl);
        wr_num = '0;
    endtask

    task automatic test_rr();
        apply_rst();
        push(1, 0, 24'h000, 10'd16);
        push(1, 1, 24'h100, 10'd16);
        push(1, 0, 24'h010, 10'd16);
        push(1, 1, 24'h110, 10'd16);
        wr_num = {10'd16, 10'd16};
        for (int i = 0; i < 4; i++) begin
            do_burst(0, 4, -1, bw, ba, brl);
            total++;
            if (!brl) begin
                bad++;
                $display("FAIL rr_req_drop: burst %0d got req still high after ack, required low", i);
            end
        end
        wr_num = '0;
    endtask

    task automatic test_prio();
        apply_rst();
        push(1, 0, 24'h000000, 10'd16);
        push(1, 0, 24'h000010, 10'd16);
        push(1, 0, 24'h000020, 10'd16);
        push(0, 1, 24'h003000, 10'd256);
        wr_num[0 +: CW] = 10'd16;
        rd_valid[1] = 1'b1;
        rd_num[CW +: CW] = 10'd0;
        for (int i = 0; i < 3; i++) do_burst(0, 4, -1, bw, ba, brl);
        wr_num = '0;
        do_burst(0, 4, -1, bw, ba, brl);
        rd_valid = '0;
        rd_num = {10'd1000, 10'd1000};
    endtask

    task automatic test_rd_elig();
        bit seen = 1'b0;
        apply_rst();
        rd_valid[0] = 1'b1;
        rd_num[0 +: CW] = 10'd769;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_req || rd_req) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rd_769: got a request, required none");
        end
        push(0, 0, 24'h001000, 10'd256);
        rd_num[0 +: CW] = 10'd768;
        do_burst(0, 4, -1, bw, ba, brl);
        rd_num[0 +: CW] = 10'd769;
        push(0, 0, 24'h001100, 10'd256);
        rd_num[0 +: CW] = 10'd768;
        do_burst(0, 4, -1, bw, ba, brl);
        rd_num[0 +: CW] = 10'd0;
        rd_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wr_req || rd_req) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rd_invalid: got a request with rd_valid=0, required none");
        end
        rd_num = {10'd1000, 10'd1000};
    endtask

    task automatic test_ch_rst();
        apply_rst();
        push(1, 0, 24'h00, 10'd16);
        push(1, 0, 24'h10, 10'd16);
        push(1, 0, 24'h20, 10'd16);
        push(1, 0, 24'h00, 10'd16);
        wr_num[0 +: CW] = 10'd16;
        do_burst(0, 4, -1, bw, ba, brl);
        do_burst(0, 4, -1, bw, ba, brl);
        do_burst(0, 6, 2, bw, ba, brl);
        total++;
        if (addr !== 24'h20) begin
            bad++;
            $display("FAIL chrst_hold: got addr=%h, required 000020", addr);
        end
        do_burst(0, 4, -1, bw, ba, brl);
        wr_num = '0;
    endtask

    task automatic test_init_end();
        bit seen = 1'b0;
        apply_rst();
        push(1, 0, 24'h00, 10'd16);
        wr_num[0 +: CW] = 10'd16;
        wait_req(0, bok);
        init_end = 1'b0;
        do_burst(0, 4, -1, bw, ba, brl);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (wr_req || rd_req) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL init_drop: got a request with init_end=0, required none");
        end
        push(1, 0, 24'h10, 10'd16);
        init_end = 1'b1;
        do_burst(0, 4, -1, bw, ba, brl);
        wr_num = '0;
    endtask

    task automatic test_rst_xfer();
        bit seen = 1'b0;
        apply_rst();
        push(1, 0, 24'h00, 10'd16);
        wr_num[0 +: CW] = 10'd16;
        wait_req(0, bok);
        wr_ack = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wr_num = '0;
        @(negedge clk);
        total++;
        if ({wr_req, rd_req, addr, len, ch_sel} !== '0) begin
            bad++;
            $display("FAIL rst_xfer: got req=%b addr=%h len=%0d sel=%b, required all 0",
                     {wr_req, rd_req}, addr, len, ch_sel);
        end
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) wr_ack = 1'b0;
            if (wr_req || rd_req || ch_sel != '0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_ack_ignored: got activity after reset, required none");
        end
    endtask

    task automatic test_alt();
        bit            ew [4];
        logic [AW-1:0] ea [4];
        ew[0] = 1'b1; ea[0] = 24'h000000;
        ew[1] = 1'b0; ea[1] = 24'h003000;
        ew[2] = 1'b1; ea[2] = 24'h000010;
        ew[3] = 1'b0; ea[3] = 24'h003100;
        rst = 1'b1;
        rst0 = 1'b0;
        wr_num[0 +: CW] = 10'd16;
        rd_valid[1] = 1'b1;
        rd_num[CW +: CW] = 10'd0;
        for (int i = 0; i < 4; i++) begin
            do_burst(1, 4, -1, bw, ba, brl);
            total++;
            if ({bw, ba} !== {ew[i], ea[i]}) begin
                bad++;
                $display("FAIL alt_%0d: got wr=%0b addr=%h, required wr=%0b addr=%h",
                         i, bw, ba, ew[i], ea[i]);
            end
        end
        wr_num = '0;
        rd_valid = '0;
        rd_num = {10'd1000, 10'd1000};
        @(negedge clk);
        rst0 = 1'b1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rst0 = 1'b1;
        init_end = 1'b0;
        wr_num = '0;
        rd_num = {10'd1000, 10'd1000};
        rd_valid = '0;
        wr_rst = '0;
        rd_rst = '0;
        wr_start = {24'h000100, 24'h000000};
        wr_end   = {24'h000200, 24'h000040};
        rd_start = {24'h003000, 24'h001000};
        rd_end   = {24'h004000, 24'h002000};
        wr_len = {10'd16, 10'd16};
        rd_len = {10'd256, 10'd256};
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        wr_ack0 = 1'b0;
        rd_ack0 = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_wrap();
        test_rr();
        test_prio();
        test_rd_elig();
        test_ch_rst();
        test_init_end();
        test_rst_xfer();
        test_alt();
        repeat (5) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending bursts, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
